mem_req_ctrl: RTL and testbench

MEM_REQ_CTRL -- requirements
Module: mem_req_ctrl

---
 rtl/mem_req_ctrl_if.sv | 37 +++
 rtl/mem_req_ctrl.sv | 96 +++++++++
 tb/tb_mem_req_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_req_ctrl_if.sv
// mem_req_ctrl_if: execute handshake, data-memory request/response and writeback bundle
// Modports: slave = mem_req_ctrl (serves execute, drives memory and writeback),
//           master = the surrounding pipeline/memory (drives requests, stall and read data).
// Optional: MISALIGN_TRAP_EN adds wb_misalign.
interface mem_req_ctrl_if;
  logic        ex_valid, ex_ready, ex_is_load, ex_is_store;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic [63:0] ex_addr, ex_wdata;
  logic        mem_read_en, mem_write_en, zero_extends, stall_from_mem;
  logic [63:0] mem_addr, mem_write_data, mem_read_data;
  logic [3:0]  mem_read_size, mem_wmask;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
`ifdef MISALIGN_TRAP_EN
  logic        wb_misalign;
`endif
  modport slave (
    input  ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_rd, ex_addr, ex_wdata,
    input  stall_from_mem, mem_read_data,
    output ex_ready, mem_read_en, mem_write_en, mem_addr, mem_write_data,
    output mem_read_size, mem_wmask, zero_extends, wb_valid, wb_rd, wb_data
`ifdef MISALIGN_TRAP_EN
    , output wb_misalign
`endif
  );
  modport master (
    output ex_valid, ex_is_load, ex_is_store, ex_funct3, ex_rd, ex_addr, ex_wdata,
    output stall_from_mem, mem_read_data,
    input  ex_ready, mem_read_en, mem_write_en, mem_addr, mem_write_data,
    input  mem_read_size, mem_wmask, zero_extends, wb_valid, wb_rd, wb_data
`ifdef MISALIGN_TRAP_EN
    , input wb_misalign
`endif
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: single-outstanding load/store sequencer between execute and data memory
// Ports: ACLK (rising edge), ARESETn (async assert, active-low),
//        bus (mem_req_ctrl_if.slave): ex_* handshake in, mem_* request/response, wb_* writeback out.
// Optional: MISALIGN_TRAP_EN traps misaligned accesses straight to writeback with wb_misalign.
module mem_req_ctrl (
  input logic ACLK,
  input logic ARESETn,
  mem_req_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state;
  logic [4:0] rd_q;
  logic is_load, is_store, mem_op, mis;
  logic [3:0] size;
  assign is_load = bus.ex_is_load;
  assign is_store = bus.ex_is_store & ~bus.ex_is_load;
  assign mem_op = is_load | is_store;
  assign size = 4'b0001 << bus.ex_funct3[1:0];
`ifdef MISALIGN_TRAP_EN
  // address bits that must be zero: none for byte, [0] half, [1:0] word, [2:0] double
  assign mis = mem_op & |(bus.ex_addr[2:0] & {&bus.ex_funct3[1:0], bus.ex_funct3[1], |bus.ex_funct3[1:0]});
`else
  assign mis = 1'b0;
`endif
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= IDLE;
      rd_q <= '0;
      bus.ex_ready <= 1'b1;
      bus.mem_read_en <= 1'b0;
      bus.mem_write_en <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_write_data <= '0;
      bus.mem_read_size <= '0;
      bus.mem_wmask <= '0;
      bus.zero_extends <= 1'b0;
      bus.wb_valid <= 1'b0;
      bus.wb_rd <= '0;
      bus.wb_data <= '0;
`ifdef MISALIGN_TRAP_EN
      bus.wb_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.ex_valid && bus.ex_ready) begin
          bus.ex_ready <= 1'b0;
          rd_q <= bus.ex_rd;
          if (mem_op && !mis) begin
            state <= ISSUE;
            bus.mem_addr <= bus.ex_addr;
            bus.mem_write_data <= bus.ex_wdata;
            bus.mem_read_size <= is_load ? size : '0;
            bus.mem_wmask <= is_store ? size : '0;
            bus.zero_extends <= is_load & bus.ex_funct3[2];
            bus.mem_read_en <= is_load;
            bus.mem_write_en <= is_store;
          end else begin
            state <= DONE;
            bus.wb_valid <= 1'b1;
            bus.wb_rd <= bus.ex_rd;
            bus.wb_data <= mem_op ? '0 : bus.ex_addr;
`ifdef MISALIGN_TRAP_EN
            bus.wb_misalign <= mis;
`endif
          end
        end
        // a store finishes straight out of ISSUE; a load finishes from WAIT once memory stops stalling
        ISSUE, WAIT: if (state == ISSUE && bus.mem_read_en) begin
          state <= WAIT;
        end else if (state == ISSUE || !bus.stall_from_mem) begin
          state <= DONE;
          bus.mem_read_en <= 1'b0;
          bus.mem_write_en <= 1'b0;
          bus.mem_addr <= '0;
          bus.mem_write_data <= '0;
          bus.mem_read_size <= '0;
          bus.mem_wmask <= '0;
          bus.zero_extends <= 1'b0;
          bus.wb_valid <= 1'b1;
          bus.wb_rd <= rd_q;
          bus.wb_data <= bus.mem_read_en ? bus.mem_read_data : '0;
        end
        DONE: begin
          state <= IDLE;
          bus.ex_ready <= 1'b1;
          bus.wb_valid <= 1'b0;
          bus.wb_rd <= '0;
          bus.wb_data <= '0;
`ifdef MISALIGN_TRAP_EN
          bus.wb_misalign <= 1'b0;
`endif
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: randomized self-checking bench for mem_req_ctrl against a latency/result model
module tb_mem_req_ctrl;
  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  int checks = 0;
  int errors = 0;
  mem_req_ctrl_if bus();
  mem_req_ctrl dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));
  always #5 ACLK = ~ACLK;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 2ms");
    $fatal(1, "timeout");
  end

  function automatic logic [64+64+4+4+1+1+1+1+1+5+64-1:0] all_outs();
    return {bus.mem_addr, bus.mem_write_data, bus.mem_read_size, bus.mem_wmask, bus.zero_extends,
            bus.mem_read_en, bus.mem_write_en, bus.ex_ready, bus.wb_valid, bus.wb_rd, bus.wb_data};
  endfunction

  task automatic drive_idle();
    bus.ex_valid = 1'b0;
    bus.ex_is_load = 1'b0;
    bus.ex_is_store = 1'b0;
    bus.ex_funct3 = 3'd0;
    bus.ex_rd = 5'd0;
    bus.ex_addr = 64'd0;
    bus.ex_wdata = 64'd0;
    bus.stall_from_mem = 1'b0;
    bus.mem_read_data = 64'd0;
  endtask

  task automatic test_reset();
    drive_idle();
    ARESETn = 1'b0;
    repeat (2) @(negedge ACLK);
    checks++;
    if (all_outs() !== {64'd0, 64'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h required ex_ready only", all_outs());
    end
    ARESETn = 1'b1;
    @(negedge ACLK);
    checks++;
    if (bus.ex_ready !== 1'b1 || bus.wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: ex_ready=%b wb_valid=%b required 1 0", bus.ex_ready, bus.wb_valid);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle following writeback.
  task automatic run_txn(input logic ld, input logic st, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] wd, input logic [4:0] rd, input int n, input logic [63:0] rdata);
    logic load, store, memop, mis, zext, got;
    logic [3:0] sz, exp_rs, exp_wm;
    logic [63:0] exp_data;
    int lat, exp_rdc, exp_wrc, rdc, wrc;
    load = ld;
    store = st & ~ld;
    memop = load | store;
    sz = 4'b0001 << f3[1:0];
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = memop && ((a % (64'd1 << f3[1:0])) != 64'd0);
`endif
    lat = (!memop || mis) ? 1 : store ? 2 : 3 + n;
    exp_data = !memop ? a : (mis || store) ? 64'd0 : rdata;
    exp_rdc = (load && !mis) ? 2 + n : 0;
    exp_wrc = (store && !mis) ? 1 : 0;
    exp_rs = load ? sz : 4'd0;
    exp_wm = store ? sz : 4'd0;
    zext = load & f3[2];
    checks++;
    if (bus.ex_ready !== 1'b1 || bus.mem_read_en !== 1'b0 || bus.mem_addr !== 64'd0) begin
      errors++;
      $display("FAIL idle_before_accept: ex_ready=%b rd_en=%b addr=%h required 1 0 0", bus.ex_ready, bus.mem_read_en, bus.mem_addr);
    end
    bus.ex_valid = 1'b1;
    bus.ex_is_load = ld;
    bus.ex_is_store = st;
    bus.ex_funct3 = f3;
    bus.ex_addr = a;
    bus.ex_wdata = wd;
    bus.ex_rd = rd;
    bus.stall_from_mem = 1'($urandom);
    bus.mem_read_data = {$urandom, $urandom};
    @(negedge ACLK);
    bus.ex_valid = 1'b0;
    bus.ex_is_load = 1'($urandom);
    bus.ex_addr = {$urandom, $urandom};
    bus.ex_rd = 5'($urandom);
    rdc = 0;
    wrc = 0;
    got = 1'b0;
    for (int k = 1; k <= lat + 20; k++) begin
      if (bus.mem_read_en) rdc++;
      if (bus.mem_write_en) wrc++;
      if (bus.mem_read_en || bus.mem_write_en) begin
        checks++;
        if ({bus.mem_addr, bus.mem_write_data, bus.mem_read_size, bus.mem_wmask, bus.zero_extends} !== {a, wd, exp_rs, exp_wm, zext}) begin
          errors++;
          $display("FAIL mem_request c%0d: addr=%h wdata=%h rs=%b wm=%b z=%b required %h %h %b %b %b",
                   k, bus.mem_addr, bus.mem_write_data, bus.mem_read_size, bus.mem_wmask, bus.zero_extends, a, wd, exp_rs, exp_wm, zext);
        end
      end
      checks++;
      if (bus.ex_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_ready c%0d: ex_ready=%b required 0", k, bus.ex_ready);
      end
      if (bus.wb_valid === 1'b1) begin
        got = 1'b1;
        checks++;
        if (k != lat) begin
          errors++;
          $display("FAIL latency: wb_valid after %0d cycles required %0d", k, lat);
        end
        checks++;
        if (bus.wb_rd !== rd || bus.wb_data !== exp_data) begin
          errors++;
          $display("FAIL wb_result: rd=%0d data=%h required rd=%0d data=%h", bus.wb_rd, bus.wb_data, rd, exp_data);
        end
`ifdef MISALIGN_TRAP_EN
        checks++;
        if (bus.wb_misalign !== mis) begin
          errors++;
          $display("FAIL wb_misalign: got %b required %b", bus.wb_misalign, mis);
        end
`endif
        break;
      end
      bus.stall_from_mem = load ? (k == 1 ? 1'($urandom) : (k <= n + 1)) : 1'($urandom);
      bus.mem_read_data = (load && k == n + 2) ? rdata : {$urandom, $urandom};
      @(negedge ACLK);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wb_timeout: no wb_valid within %0d cycles, required at %0d", lat + 20, lat);
    end
    checks++;
    if (rdc != exp_rdc || wrc != exp_wrc) begin
      errors++;
      $display("FAIL en_cycles: read_en=%0d write_en=%0d required %0d %0d", rdc, wrc, exp_rdc, exp_wrc);
    end
    bus.stall_from_mem = 1'($urandom);
    @(negedge ACLK);
    checks++;
    if (bus.wb_valid !== 1'b0 || bus.ex_ready !== 1'b1 || bus.wb_data !== 64'd0) begin
      errors++;
      $display("FAIL after_done: wb_valid=%b ex_ready=%b wb_data=%h required 0 1 0", bus.wb_valid, bus.ex_ready, bus.wb_data);
    end
  endtask

  task automatic test_directed();
    run_txn(1'b1, 1'b0, 3'b000, 64'h8000_0010, 64'h0, 5'd3, 3, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(1'b0, 1'b1, 3'b011, 64'h8000_0008, 64'h1122_3344_5566_7788, 5'd7, 0, 64'h0);
    run_txn(1'b0, 1'b0, 3'b101, 64'h2A, 64'h55, 5'd5, 0, 64'h0);
    run_txn(1'b1, 1'b0, 3'b010, 64'h8000_0002, 64'h0, 5'd9, 1, 64'h0123_4567_89AB_CDEF);
    run_txn(1'b1, 1'b1, 3'b110, 64'h8000_0004, 64'hDEAD, 5'd11, 0, 64'h0000_0000_CAFE_F00D);
    run_txn(1'b0, 1'b1, 3'b001, 64'h8000_0001, 64'hBEEF, 5'd12, 0, 64'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int kind;
      logic [63:0] a;
      kind = $urandom_range(0, 3);
      a = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 0) a[2:0] = 3'd0;
      run_txn(kind == 1 || kind == 3, kind == 2 || kind == 3, 3'($urandom), a, {$urandom, $urandom},
              5'($urandom), $urandom_range(0, 4), {$urandom, $urandom});
    end
  endtask

  task automatic test_reset_during_wait();
    logic seen;
    bus.ex_valid = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.ex_is_store = 1'b0;
    bus.ex_funct3 = 3'b011;
    bus.ex_addr = 64'h8000_0040;
    bus.ex_rd = 5'd4;
    bus.stall_from_mem = 1'b1;
    @(negedge ACLK);
    bus.ex_valid = 1'b0;
    @(negedge ACLK);
    checks++;
    if (bus.mem_read_en !== 1'b1) begin
      errors++;
      $display("FAIL wait_read_en: got %b required 1", bus.mem_read_en);
    end
    #2 ARESETn = 1'b0;
    #1;
    checks++;
    if (all_outs() !== {64'd0, 64'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 64'd0}) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h required ex_ready only", all_outs());
    end
    @(negedge ACLK);
    ARESETn = 1'b1;
    bus.stall_from_mem = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge ACLK);
      if (bus.wb_valid !== 1'b0 || bus.mem_read_en !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen || bus.ex_ready !== 1'b1) begin
      errors++;
      $display("FAIL abandoned_txn: activity=%b ex_ready=%b required 0 1", seen, bus.ex_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] rdy, rde, wbv;
    logic [9:0] exp_rdy, exp_rde, exp_wbv;
    exp_rdy = 10'b11_0001_0001;
    exp_rde = 10'b00_0110_0110;
    exp_wbv = 10'b00_1000_1000;
    bus.ex_valid = 1'b1;
    bus.ex_is_load = 1'b1;
    bus.ex_is_store = 1'b0;
    bus.ex_funct3 = 3'b100;
    bus.ex_addr = 64'h8000_0100;
    bus.ex_rd = 5'd1;
    bus.stall_from_mem = 1'b0;
    bus.mem_read_data = 64'h0000_0000_0000_00AB;
    for (int c = 0; c < 10; c++) begin
      rdy[c] = bus.ex_ready;
      rde[c] = bus.mem_read_en;
      wbv[c] = bus.wb_valid;
      if (bus.wb_valid === 1'b1) begin
        checks++;
        if (bus.wb_rd !== (c == 3 ? 5'd1 : 5'd2)) begin
          errors++;
          $display("FAIL b2b_wb_rd c%0d: got %0d required %0d", c, bus.wb_rd, c == 3 ? 1 : 2);
        end
      end
      if (c == 1) bus.ex_rd = 5'd2;
      if (c == 5) bus.ex_valid = 1'b0;
      @(negedge ACLK);
    end
    checks++;
    if (rdy !== exp_rdy || rde !== exp_rde || wbv !== exp_wbv) begin
      errors++;
      $display("FAIL back_to_back: ready=%b rd_en=%b wb=%b required %b %b %b", rdy, rde, wbv, exp_rdy, exp_rde, exp_wbv);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_reset_during_wait();
    drive_idle();
    test_back_to_back();
    drive_idle();
    run_txn(1'b0, 1'b0, 3'b000, 64'h77, 64'h0, 5'd30, 0, 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
